// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
//   PS/2 receiver front-end. Synchronises and glitch-filters the raw PS/2
//   clock, deframes 11-bit packets (start, 8 data LSB-first, odd parity,
//   stop) and presents each good scan code as a one-cycle strobe. Bad
//   frames (parity, stop bit or inter-edge timeout) are dropped and flagged.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   code        out  last good scan code, held until the next good frame
//   code_valid  out  one-cycle pulse: code updated this cycle
//   frame_err   out  one-cycle pulse: frame rejected
//   busy        out  high while a frame is in progress
// ---------------------------------------------------------------------------
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECV   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic                  clk_s1, clk_s2;
    logic                  dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] hist;
    logic                  filt, filt_d;
    logic                  fall;

    logic [1:0]            state;
    logic [3:0]            bit_cnt;
    logic [7:0]            sr;
    logic                  par;
    logic [TW-1:0]         to_cnt;
    logic                  to_hit;

    // Two-flop synchronisers for both pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock only changes after FILTER_LEN identical samples;
    // shorter pulses leave it holding its previous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist   <= '1;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            hist <= {hist[FILTER_LEN-2:0], clk_s2};
            if (hist == '0)
                filt <= 1'b0;
            else if (hist == '1)
                filt <= 1'b1;
            filt_d <= filt;
        end
    end

    assign fall   = filt_d & ~filt;
    assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy   = (state != IDLE);

    // Deframing FSM. A falling edge takes priority over timeout expiry in
    // the same cycle: the counter clears and the frame continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sr         <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE) begin
                to_cnt <= '0;
                // A high data level on a falling edge is line noise, not an error
                if (fall && !dat_s2) begin
                    state   <= RECV;
                    bit_cnt <= '0;
                end
            end else if (fall) begin
                to_cnt <= '0;
                case (state)
                    RECV: begin
                        sr      <= {dat_s2, sr[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    default: begin
                        if (dat_s2 && (^{sr, par})) begin
                            code       <= sr;
                            code_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end else if (to_hit) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;

    localparam int HP = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Pulse monitor
    int cv_cnt    = 0;
    int fe_cnt    = 0;
    int wide_cnt  = 0;
    int both_cnt  = 0;
    logic prev_cv = 1'b0;
    logic prev_fe = 1'b0;

    ps2_rx #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (code),
        .code_valid(code_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid === 1'b1) cv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if ((code_valid === 1'b1 && prev_cv) || (frame_err === 1'b1 && prev_fe)) wide_cnt++;
        if (code_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
        prev_cv = (code_valid === 1'b1);
        prev_fe = (frame_err === 1'b1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send the first nbits of a frame; glitch_at >= 0 inserts a 3-clk low
    // pulse on ps2_clk during the high phase before that bit's falling edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int nbits, input int glitch_at);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_clks(HP / 2);
            if (i == glitch_at) begin
                ps2_clk = 1'b0;
                wait_clks(3);
                ps2_clk = 1'b1;
            end
            wait_clks(HP / 2);
            ps2_clk = 1'b0;
            wait_clks(HP);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_clks(HP);
    endtask

    task automatic check_frame(input string name, input int cv0, input int fe0,
                               input int dcv, input int dfe, input logic [7:0] exp_code);
        total_cnt++;
        if ((cv_cnt - cv0) !== dcv) $display("FAIL %s code_valid pulses: got %0d want %0d", name, cv_cnt - cv0, dcv);
        else pass_cnt++;
        total_cnt++;
        if ((fe_cnt - fe0) !== dfe) $display("FAIL %s frame_err pulses: got %0d want %0d", name, fe_cnt - fe0, dfe);
        else pass_cnt++;
        total_cnt++;
        if (code !== exp_code) $display("FAIL %s code: got %h want %h", name, code, exp_code);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s busy after frame: got %b want 0", name, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        wait_clks(3);
        total_cnt++;
        if ({code, code_valid, frame_err, busy} !== 11'h0)
            $display("FAIL reset outputs: got code=%h cv=%b fe=%b busy=%b want 0", code, code_valid, frame_err, busy);
        else pass_cnt++;
        rst_n = 1'b1;
        wait_clks(20);
    endtask

    task automatic test_good_frame;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        check_frame("good_1c", cv0, fe0, 1, 0, 8'h1C);
    endtask

    task automatic test_bad_parity;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
        check_frame("bad_parity", cv0, fe0, 0, 1, 8'h1C);
    endtask

    task automatic test_bad_stop;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(8'hF0, 1'b1, 1'b0, 11, -1);
        check_frame("bad_stop", cv0, fe0, 0, 1, 8'h1C);
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
        check_frame("good_f0", cv0, fe0, 1, 0, 8'hF0);
    endtask

    task automatic test_glitch;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        ps2_clk = 1'b0;
        wait_clks(3);
        ps2_clk = 1'b1;
        wait_clks(20);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_glitch busy: got %b want 0", busy);
        else pass_cnt++;
        send_frame(8'h5A, 1'b1, 1'b1, 11, 5);
        check_frame("glitch_5a", cv0, fe0, 1, 0, 8'h5A);
    endtask

    task automatic test_timeout;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(8'h00, 1'b0, 1'b1, 6, -1);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL timeout partial busy: got %b want 1", busy);
        else pass_cnt++;
        wait_clks(1000);
        check_frame("timeout", cv0, fe0, 0, 1, 8'h5A);
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h29, 1'b0, 1'b1, 11, -1);
        check_frame("after_to_29", cv0, fe0, 1, 0, 8'h29);
    endtask

    task automatic test_reset_midframe;
        int cv0, fe0;
        send_frame(8'hFF, 1'b0, 1'b1, 5, -1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({code, code_valid, frame_err, busy} !== 11'h0)
            $display("FAIL midframe reset outputs: got code=%h cv=%b fe=%b busy=%b want 0", code, code_valid, frame_err, busy);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(20);
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        check_frame("after_rst_1c", cv0, fe0, 1, 0, 8'h1C);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_bad_stop();
        test_glitch();
        test_timeout();
        test_reset_midframe();
        total_cnt++;
        if (wide_cnt !== 0) $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt);
        else pass_cnt++;
        total_cnt++;
        if (both_cnt !== 0) $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
